// File: rtl/group_mac_pkg.sv
// Shared types and the saturating-add helper for the streaming group MAC.
// All per-lane arithmetic funnels through sat_add so both number modes saturate identically.
package group_mac_pkg;

    localparam int SAT_W          = 64;
    localparam int MAX_ACC_WIDTH  = SAT_W - 1;
    localparam int MIN_PIPE_DEPTH = 1;
    localparam int MAX_PIPE_DEPTH = 4;

    localparam logic signed [SAT_W:0] SAT_ONE = {{SAT_W{1'b0}}, 1'b1};

    typedef struct packed {
        logic valid;
        logic last;
        logic sgn;
    } beat_t;

    typedef struct packed {
        logic [SAT_W-1:0] sum;
        logic             ovf;
    } sat_res_t;

    // Operands arrive already extended to SAT_W bits in the requested mode.
    function automatic sat_res_t sat_add(
        input logic [SAT_W-1:0] value,
        input logic [SAT_W-1:0] addend,
        input int               width,
        input logic             is_signed
    );
        logic signed [SAT_W:0] v_x;
        logic signed [SAT_W:0] a_x;
        logic signed [SAT_W:0] s;
        logic signed [SAT_W:0] hi;
        logic signed [SAT_W:0] lo;
        sat_res_t              res;
        if (is_signed) begin
            v_x = $signed({value[SAT_W-1], value});
            a_x = $signed({addend[SAT_W-1], addend});
            hi  = (SAT_ONE <<< (width - 1)) - SAT_ONE;
            lo  = -(SAT_ONE <<< (width - 1));
        end else begin
            v_x = $signed({1'b0, value});
            a_x = $signed({1'b0, addend});
            hi  = (SAT_ONE <<< width) - SAT_ONE;
            lo  = '0;
        end
        s       = v_x + a_x;
        res.sum = s[SAT_W-1:0];
        res.ovf = 1'b0;
        if (s > hi) begin
            res.sum = hi[SAT_W-1:0];
            res.ovf = 1'b1;
        end else if (s < lo) begin
            res.sum = lo[SAT_W-1:0];
            res.ovf = 1'b1;
        end else begin
            res.ovf = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/group_mac_stream_lane.sv
// One MAC lane: operand register, optional product registers, saturating accumulator
// with sticky overflow, and the lane's slot of the frame-result register.
module mac_lane
    import group_mac_pkg::*;
#(
    parameter int IMG_WIDTH  = 16,
    parameter int KER_WIDTH  = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int PIPE_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_mul_sgn,
    input  logic                 i_acc_val,
    input  logic                 i_acc_last,
    input  logic                 i_acc_sgn,
    input  logic [IMG_WIDTH-1:0] i_img,
    input  logic [KER_WIDTH-1:0] i_ker,
    output logic [ACC_WIDTH-1:0] o_data,
    output logic                 o_ovf
);

    localparam int PROD_W = IMG_WIDTH + KER_WIDTH;

    logic [IMG_WIDTH-1:0] r_img;
    logic [KER_WIDTH-1:0] r_ker;
    logic [PROD_W-1:0]    w_img_x;
    logic [PROD_W-1:0]    w_ker_x;
    logic [PROD_W-1:0]    w_prod_mul;
    logic [PROD_W-1:0]    w_prod_acc;
    logic [SAT_W-1:0]     w_acc_x;
    logic [SAT_W-1:0]     w_prod_x;
    sat_res_t             w_sat;
    logic [ACC_WIDTH-1:0] w_sum;
    logic                 w_unused_sum_hi;
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_sticky;
    logic [ACC_WIDTH-1:0] r_data;
    logic                 r_ovf;

    // Operand capture; bubbles are tracked by the top's valid bits, so data loads freely.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_img <= '0;
            r_ker <= '0;
        end else if (i_en) begin
            r_img <= i_img;
            r_ker <= i_ker;
        end
    end

    // Extending both operands to the product width makes one multiplier serve both modes.
    always_comb begin
        if (i_mul_sgn) begin
            w_img_x = {{KER_WIDTH{r_img[IMG_WIDTH-1]}}, r_img};
            w_ker_x = {{IMG_WIDTH{r_ker[KER_WIDTH-1]}}, r_ker};
        end else begin
            w_img_x = {{KER_WIDTH{1'b0}}, r_img};
            w_ker_x = {{IMG_WIDTH{1'b0}}, r_ker};
        end
        w_prod_mul = w_img_x * w_ker_x;
    end

    generate
        if (PIPE_DEPTH == 1) begin : g_no_preg
            assign w_prod_acc = w_prod_mul;
        end else begin : g_preg
            logic [PROD_W-1:0] r_prod [PIPE_DEPTH-1];

            // Product delay line matching the control pipeline depth.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < PIPE_DEPTH - 1; s++) begin
                        r_prod[s] <= '0;
                    end
                end else if (i_en) begin
                    r_prod[0] <= w_prod_mul;
                    for (int s = 1; s < PIPE_DEPTH - 1; s++) begin
                        r_prod[s] <= r_prod[s-1];
                    end
                end
            end

            assign w_prod_acc = r_prod[PIPE_DEPTH-2];
        end
    endgenerate

    // Extend accumulator and product in the mode of the beat being accumulated.
    always_comb begin
        if (i_acc_sgn) begin
            w_acc_x  = {{(SAT_W-ACC_WIDTH){r_acc[ACC_WIDTH-1]}}, r_acc};
            w_prod_x = {{(SAT_W-PROD_W){w_prod_acc[PROD_W-1]}}, w_prod_acc};
        end else begin
            w_acc_x  = {{(SAT_W-ACC_WIDTH){1'b0}}, r_acc};
            w_prod_x = {{(SAT_W-PROD_W){1'b0}}, w_prod_acc};
        end
        w_sat = sat_add(w_acc_x, w_prod_x, ACC_WIDTH, i_acc_sgn);
    end

    assign w_sum           = w_sat.sum[ACC_WIDTH-1:0];
    assign w_unused_sum_hi = ^w_sat.sum[SAT_W-1:ACC_WIDTH];

    // Accumulate; a last beat publishes the sum and restarts the frame on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_sticky <= 1'b0;
            r_data   <= '0;
            r_ovf    <= 1'b0;
        end else if (i_en && i_acc_val) begin
            if (i_acc_last) begin
                r_data   <= w_sum;
                r_ovf    <= r_sticky | w_sat.ovf;
                r_acc    <= '0;
                r_sticky <= 1'b0;
            end else begin
                r_acc    <= w_sum;
                r_sticky <= r_sticky | w_sat.ovf;
            end
        end
    end

    assign o_data = r_data;
    assign o_ovf  = r_ovf;

endmodule

// File: rtl/group_mac_stream.sv
// Streaming group MAC: GROUP_NB lanes accumulate image x kernel over a frame ended by in_last,
// then present saturated sums, overflow flags and beat count behind a valid/ready register.
module group_mac_stream
    import group_mac_pkg::*;
#(
    parameter int GROUP_NB   = 4,
    parameter int IMG_WIDTH  = 16,
    parameter int KER_WIDTH  = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int PIPE_DEPTH = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [GROUP_NB*IMG_WIDTH-1:0] img,
    input  logic [GROUP_NB*KER_WIDTH-1:0] ker,
    input  logic                          cfg_signed,
    input  logic                          in_val,
    input  logic                          in_last,
    output logic                          in_rdy,
    output logic                          out_val,
    input  logic                          out_rdy,
    output logic [GROUP_NB*ACC_WIDTH-1:0] out_data,
    output logic [GROUP_NB-1:0]           out_ovf,
    output logic [CNT_WIDTH-1:0]          out_cnt
);

    generate
        if (ACC_WIDTH < IMG_WIDTH + KER_WIDTH + 1 || ACC_WIDTH > MAX_ACC_WIDTH ||
            PIPE_DEPTH < MIN_PIPE_DEPTH || PIPE_DEPTH > MAX_PIPE_DEPTH) begin : g_bad_params
            $error("group_mac_stream: illegal ACC_WIDTH or PIPE_DEPTH");
        end
    endgenerate

    logic                 w_stall;
    logic                 w_en;
    beat_t                r_pipe [PIPE_DEPTH];
    beat_t                w_acc_beat;
    logic                 w_acc_fire;
    logic                 w_frame_end;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_out_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_inc;
    logic                 r_out_val;

    // A held result freezes the whole datapath; in_rdy mirrors that combinationally.
    assign w_stall     = r_out_val & ~out_rdy;
    assign w_en        = ~w_stall;
    assign in_rdy      = ~rst & ~w_stall;
    assign w_acc_beat  = r_pipe[PIPE_DEPTH-1];
    assign w_acc_fire  = w_en & w_acc_beat.valid;
    assign w_frame_end = w_acc_fire & w_acc_beat.last;
    assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Control pipeline; while enabled and out of reset, in_val equals the accept strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < PIPE_DEPTH; s++) begin
                r_pipe[s] <= '0;
            end
        end else if (w_en) begin
            r_pipe[0].valid <= in_val;
            r_pipe[0].last  <= in_last;
            r_pipe[0].sgn   <= cfg_signed;
            for (int s = 1; s < PIPE_DEPTH; s++) begin
                r_pipe[s] <= r_pipe[s-1];
            end
        end
    end

    // Beat counter, published and cleared together with the lane sums.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_out_cnt <= '0;
        end else if (w_acc_fire) begin
            if (w_acc_beat.last) begin
                r_out_cnt <= w_cnt_inc;
                r_cnt     <= '0;
            end else begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    // Result valid: a new frame end outranks a same-edge consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_val <= 1'b0;
        end else if (w_frame_end) begin
            r_out_val <= 1'b1;
        end else if (out_rdy) begin
            r_out_val <= 1'b0;
        end
    end

    generate
        for (genvar g = 0; g < GROUP_NB; g++) begin : g_lane
            mac_lane #(
                .IMG_WIDTH (IMG_WIDTH),
                .KER_WIDTH (KER_WIDTH),
                .ACC_WIDTH (ACC_WIDTH),
                .PIPE_DEPTH(PIPE_DEPTH)
            ) u_lane (
                .clk       (clk),
                .rst       (rst),
                .i_en      (w_en),
                .i_mul_sgn (r_pipe[0].sgn),
                .i_acc_val (w_acc_beat.valid),
                .i_acc_last(w_acc_beat.last),
                .i_acc_sgn (w_acc_beat.sgn),
                .i_img     (img[g*IMG_WIDTH +: IMG_WIDTH]),
                .i_ker     (ker[g*KER_WIDTH +: KER_WIDTH]),
                .o_data    (out_data[g*ACC_WIDTH +: ACC_WIDTH]),
                .o_ovf     (out_ovf[g])
            );
        end
    endgenerate

    assign out_val = r_out_val;
    assign out_cnt = r_out_cnt;

endmodule

// File: tb/tb_group_mac_stream.sv
// Directed bench for group_mac_stream built with a 33-bit accumulator so saturation is reachable.
module tb_group_mac_stream;

    localparam int NB    = 4;
    localparam int IW    = 16;
    localparam int KW    = 16;
    localparam int ACC_W = 33;
    localparam int PD    = 2;
    localparam int CW    = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [NB*IW-1:0]    img;
    logic [NB*KW-1:0]    ker;
    logic                cfg_signed;
    logic                in_val;
    logic                in_last;
    logic                in_rdy;
    logic                out_val;
    logic                out_rdy;
    logic [NB*ACC_W-1:0] out_data;
    logic [NB-1:0]       out_ovf;
    logic [CW-1:0]       out_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    group_mac_stream #(
        .GROUP_NB  (NB),
        .IMG_WIDTH (IW),
        .KER_WIDTH (KW),
        .ACC_WIDTH (ACC_W),
        .PIPE_DEPTH(PD),
        .CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .img       (img),
        .ker       (ker),
        .cfg_signed(cfg_signed),
        .in_val    (in_val),
        .in_last   (in_last),
        .in_rdy    (in_rdy),
        .out_val   (out_val),
        .out_rdy   (out_rdy),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_cnt   (out_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [ACC_W-1:0] lane_of(input int i);
        lane_of = out_data[i*ACC_W +: ACC_W];
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [15:0] i0, input logic [15:0] k0,
                        input logic [15:0] i1, input logic [15:0] k1,
                        input logic sgn, input logic last);
        img        = {32'h0, i1, i0};
        ker        = {32'h0, k1, k0};
        cfg_signed = sgn;
        in_val     = 1'b1;
        in_last    = last;
        tick();
    endtask

    task automatic wait_out(output int cyc, output bit ok);
        in_val  = 1'b0;
        in_last = 1'b0;
        cyc     = 0;
        ok      = 1'b0;
        while (!ok && cyc < 10) begin
            if (out_val === 1'b1) ok = 1'b1;
            else begin
                tick();
                cyc++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_val = 1'b0; in_last = 1'b0; out_rdy = 1'b1;
        img = '0; ker = '0; cfg_signed = 1'b0;
        @(negedge clk);
        tick(); tick();
        n_tests++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_in_rdy got %b exp 0", in_rdy); end
        n_tests++; if (out_val !== 1'b0) begin n_fail++; $display("FAIL reset_out_val got %b exp 0", out_val); end
        n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %h exp 0", out_data); end
        n_tests++; if (out_ovf !== 4'b0000) begin n_fail++; $display("FAIL reset_out_ovf got %b exp 0", out_ovf); end
        n_tests++; if (out_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_out_cnt got %0d exp 0", out_cnt); end
        rst = 1'b0;
        #1;
        n_tests++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_rdy got %b exp 1", in_rdy); end
    endtask

    task automatic test_signed_frame();
        int c; bit ok;
        out_rdy = 1'b1;
        send(16'd3,     16'd4,     16'd0, 16'd0, 1'b1, 1'b0);
        send(16'hFFFE,  16'd7,     16'd0, 16'd0, 1'b1, 1'b0);
        send(16'd5,     16'hFFFF,  16'd0, 16'd0, 1'b1, 1'b1);
        wait_out(c, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL t1_out_val_timeout got 0 exp 1"); end
        n_tests++; if (c != PD) begin n_fail++; $display("FAIL t1_latency got %0d exp %0d", c, PD); end
        n_tests++; if (lane_of(0) !== 33'h1_FFFF_FFF9) begin n_fail++; $display("FAIL t1_lane0 got %h exp 1fffffff9", lane_of(0)); end
        for (int l = 1; l < NB; l++) begin
            n_tests++; if (lane_of(l) !== 33'h0) begin n_fail++; $display("FAIL t1_lane%0d got %h exp 0", l, lane_of(l)); end
        end
        n_tests++; if (out_cnt !== 16'd3) begin n_fail++; $display("FAIL t1_cnt got %0d exp 3", out_cnt); end
        n_tests++; if (out_ovf !== 4'b0000) begin n_fail++; $display("FAIL t1_ovf got %b exp 0000", out_ovf); end
        tick();
        n_tests++; if (out_val !== 1'b0) begin n_fail++; $display("FAIL t1_consumed got %b exp 0", out_val); end
    endtask

    task automatic test_unsigned_sat();
        int c; bit ok;
        out_rdy = 1'b1;
        send(16'hFFFF, 16'hFFFF, 16'd1, 16'd1, 1'b0, 1'b0);
        send(16'hFFFF, 16'hFFFF, 16'd1, 16'd1, 1'b0, 1'b0);
        send(16'hFFFF, 16'hFFFF, 16'd1, 16'd1, 1'b0, 1'b1);
        wait_out(c, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL t2_out_val_timeout got 0 exp 1"); end
        n_tests++; if (lane_of(0) !== 33'h1_FFFF_FFFF) begin n_fail++; $display("FAIL t2_lane0_sat got %h exp 1ffffffff", lane_of(0)); end
        n_tests++; if (lane_of(1) !== 33'd3) begin n_fail++; $display("FAIL t2_lane1 got %h exp 3", lane_of(1)); end
        n_tests++; if (out_ovf !== 4'b0001) begin n_fail++; $display("FAIL t2_ovf got %b exp 0001", out_ovf); end
        n_tests++; if (out_cnt !== 16'd3) begin n_fail++; $display("FAIL t2_cnt got %0d exp 3", out_cnt); end
        tick();
        send(16'd1, 16'd1, 16'd0, 16'd0, 1'b0, 1'b1);
        wait_out(c, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL t2b_out_val_timeout got 0 exp 1"); end
        n_tests++; if (lane_of(0) !== 33'd1) begin n_fail++; $display("FAIL t2b_lane0 got %h exp 1", lane_of(0)); end
        n_tests++; if (lane_of(1) !== 33'd0) begin n_fail++; $display("FAIL t2b_lane1 got %h exp 0", lane_of(1)); end
        n_tests++; if (out_ovf !== 4'b0000) begin n_fail++; $display("FAIL t2b_ovf got %b exp 0000", out_ovf); end
        n_tests++; if (out_cnt !== 16'd1) begin n_fail++; $display("FAIL t2b_cnt got %0d exp 1", out_cnt); end
        tick();
    endtask

    // -32768 * 32767 = -1073709056: four beats stay in range, the fifth saturates.
    task automatic test_signed_sat();
        int c; bit ok;
        out_rdy = 1'b1;
        for (int b = 0; b < 4; b++) send(16'h8000, 16'h7FFF, 16'd0, 16'd0, 1'b1, (b == 3));
        wait_out(c, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL t3a_out_val_timeout got 0 exp 1"); end
        n_tests++; if (lane_of(0) !== 33'h1_0002_0000) begin n_fail++; $display("FAIL t3a_lane0 got %h exp 100020000", lane_of(0)); end
        n_tests++; if (out_ovf !== 4'b0000) begin n_fail++; $display("FAIL t3a_ovf got %b exp 0000", out_ovf); end
        n_tests++; if (out_cnt !== 16'd4) begin n_fail++; $display("FAIL t3a_cnt got %0d exp 4", out_cnt); end
        tick();
        for (int b = 0; b < 5; b++) send(16'h8000, 16'h7FFF, 16'd0, 16'd0, 1'b1, (b == 4));
        wait_out(c, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL t3b_out_val_timeout got 0 exp 1"); end
        n_tests++; if (lane_of(0) !== 33'h1_0000_0000) begin n_fail++; $display("FAIL t3b_lane0_sat got %h exp 100000000", lane_of(0)); end
        n_tests++; if (out_ovf !== 4'b0001) begin n_fail++; $display("FAIL t3b_ovf got %b exp 0001", out_ovf); end
        n_tests++; if (out_cnt !== 16'd5) begin n_fail++; $display("FAIL t3b_cnt got %0d exp 5", out_cnt); end
        tick();
    endtask

    // Frame A = 2*10+3*10 = 50, frame B = 1+2+3 = 6, B streamed while A is held.
    task automatic test_backpressure();
        logic [15:0]      bi [5];
        logic [15:0]      bk [5];
        logic             bl [5];
        logic [ACC_W-1:0] res [2];
        logic [CW-1:0]    cnts [2];
        int  idx = 0;
        int  stall_seen = 0;
        int  got = 0;
        bit  rdy_bad = 1'b0;
        bit  hold_bad = 1'b0;
        bit  acc;
        bi = '{16'd2, 16'd3, 16'd1, 16'd2, 16'd3};
        bk = '{16'd10, 16'd10, 16'd1, 16'd1, 16'd1};
        bl = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        cfg_signed = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 2; cyc++) begin
            if (idx < 5) begin
                img = {48'h0, bi[idx]}; ker = {48'h0, bk[idx]};
                in_val = 1'b1; in_last = bl[idx];
            end else begin
                in_val = 1'b0; in_last = 1'b0;
            end
            out_rdy = (stall_seen >= 5);
            #1;
            if (out_val && !out_rdy) begin
                stall_seen++;
                if (in_rdy !== 1'b0) rdy_bad = 1'b1;
                if (lane_of(0) !== 33'd50) hold_bad = 1'b1;
            end
            if (out_val && out_rdy) begin
                res[got] = lane_of(0); cnts[got] = out_cnt; got++;
            end
            acc = in_val && in_rdy;
            tick();
            if (acc) idx++;
        end
        in_val = 1'b0; in_last = 1'b0; out_rdy = 1'b1;
        n_tests++; if (got != 2) begin n_fail++; $display("FAIL t4_results got %0d exp 2", got); end
        n_tests++; if (stall_seen != 5) begin n_fail++; $display("FAIL t4_stall_cycles got %0d exp 5", stall_seen); end
        n_tests++; if (rdy_bad) begin n_fail++; $display("FAIL t4_in_rdy_during_stall got 1 exp 0"); end
        n_tests++; if (hold_bad) begin n_fail++; $display("FAIL t4_hold_A got changed exp 50"); end
        n_tests++; if (idx != 5) begin n_fail++; $display("FAIL t4_beats_accepted got %0d exp 5", idx); end
        if (got == 2) begin
            n_tests++; if (res[0] !== 33'd50) begin n_fail++; $display("FAIL t4_A_sum got %0d exp 50", res[0]); end
            n_tests++; if (cnts[0] !== 16'd2) begin n_fail++; $display("FAIL t4_A_cnt got %0d exp 2", cnts[0]); end
            n_tests++; if (res[1] !== 33'd6) begin n_fail++; $display("FAIL t4_B_sum got %0d exp 6", res[1]); end
            n_tests++; if (cnts[1] !== 16'd3) begin n_fail++; $display("FAIL t4_B_cnt got %0d exp 3", cnts[1]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [ACC_W-1:0] vals [16];
        logic [CW-1:0]    cnts [16];
        int n = 0;
        int first = -1;
        int lastc = -1;
        out_rdy = 1'b1; cfg_signed = 1'b0;
        for (int c = 0; c < 14; c++) begin
            if (c < 8) begin
                img = {48'h0, 16'(c + 1)}; ker = {48'h0, 16'd1};
                in_val = 1'b1; in_last = 1'b1;
            end else begin
                in_val = 1'b0; in_last = 1'b0;
            end
            #1;
            if (out_val === 1'b1) begin
                vals[n] = lane_of(0); cnts[n] = out_cnt; n++;
                if (first < 0) first = c;
                lastc = c;
            end
            tick();
        end
        n_tests++; if (n != 8) begin n_fail++; $display("FAIL t5_count got %0d exp 8", n); end
        n_tests++; if (first != PD + 1) begin n_fail++; $display("FAIL t5_first_cycle got %0d exp %0d", first, PD + 1); end
        n_tests++; if (lastc - first + 1 != 8) begin n_fail++; $display("FAIL t5_continuous got span %0d exp 8", lastc - first + 1); end
        for (int i = 0; i < 8 && i < n; i++) begin
            n_tests++; if (vals[i] !== 33'(i + 1)) begin n_fail++; $display("FAIL t5_data%0d got %0d exp %0d", i, vals[i], i + 1); end
            n_tests++; if (cnts[i] !== 16'd1) begin n_fail++; $display("FAIL t5_cnt%0d got %0d exp 1", i, cnts[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int c; bit ok;
        out_rdy = 1'b0;
        send(16'd7,   16'd1, 16'd0, 16'd0, 1'b0, 1'b1);
        send(16'd100, 16'd1, 16'd0, 16'd0, 1'b0, 1'b0);
        send(16'd100, 16'd1, 16'd0, 16'd0, 1'b0, 1'b0);
        in_val = 1'b0; in_last = 1'b0;
        #1;
        n_tests++; if (out_val !== 1'b1) begin n_fail++; $display("FAIL t6_pre_out_val got %b exp 1", out_val); end
        n_tests++; if (lane_of(0) !== 33'd7) begin n_fail++; $display("FAIL t6_pre_lane0 got %0d exp 7", lane_of(0)); end
        rst = 1'b1;
        #1;
        n_tests++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL t6_in_rdy_in_rst got %b exp 0", in_rdy); end
        tick();
        rst = 1'b0;
        #1;
        n_tests++; if (out_val !== 1'b0) begin n_fail++; $display("FAIL t6_out_val_after_rst got %b exp 0", out_val); end
        n_tests++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL t6_in_rdy_after_rst got %b exp 1", in_rdy); end
        n_tests++; if (lane_of(0) !== 33'd0) begin n_fail++; $display("FAIL t6_data_after_rst got %0d exp 0", lane_of(0)); end
        out_rdy = 1'b1;
        send(16'd2, 16'd2, 16'd0, 16'd0, 1'b0, 1'b1);
        wait_out(c, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL t6_out_val_timeout got 0 exp 1"); end
        n_tests++; if (lane_of(0) !== 33'd4) begin n_fail++; $display("FAIL t6_lane0 got %0d exp 4", lane_of(0)); end
        n_tests++; if (out_cnt !== 16'd1) begin n_fail++; $display("FAIL t6_cnt got %0d exp 1", out_cnt); end
        n_tests++; if (out_ovf !== 4'b0000) begin n_fail++; $display("FAIL t6_ovf got %b exp 0000", out_ovf); end
        tick();
    endtask

    initial begin
        test_reset();
        test_signed_frame();
        test_unsigned_sat();
        test_signed_sat();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
